// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin fetch/data arbiter driving a byte-serial, big-endian memory port.
// Optional feature: MEM_CTRL_ALIGN_CHECK_EN rejects misaligned half/word/fetch accesses with err.
`default_nettype none
`timescale 1ns/1ps

module dmem_port_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_data,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant_data;
    logic              owner_data;
    logic              rw;
    logic [1:0]        last;
    logic [1:0]        k;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    logic              grant_data;
    logic              any_req;
    logic              reserved;
    logic              misaligned;
    logic [1:0]        req_last;
    logic [1:0]        lane;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    // Ties go to the port that was not granted last.
    assign grant_data = d_req && (!i_req || !last_grant_data);
    assign any_req    = i_req | d_req;
    assign reserved   = grant_data && (d_size == 2'b11);

    always_comb begin
        req_last = 2'd3;
        if (grant_data) begin
            case (d_size)
                2'b00:   req_last = 2'd0;
                2'b01:   req_last = 2'd1;
                default: req_last = 2'd3;
            endcase
        end
    end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic err_r;

    assign misaligned = grant_data
                      ? ((d_size == 2'b01 && d_addr[0]) || (d_size == 2'b10 && d_addr[1:0] != 2'b00))
                      : (i_addr[1:0] != 2'b00);
    assign err = err_r;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    // Byte k of an N-byte access lives in lane N-1-k (big-endian).
    assign lane      = last - k;
    assign mem_en    = (state == XFER);
    assign mem_we    = (state == XFER) && rw;
    assign mem_addr  = (state == XFER) ? (addr + ADDR_W'(k)) : '0;
    assign mem_wdata = ((state == XFER) && rw) ? wdata[{lane, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last_grant_data <= 1'b0;
            owner_data      <= 1'b0;
            rw              <= 1'b0;
            last            <= 2'd0;
            k               <= 2'd0;
            addr            <= '0;
            wdata           <= 32'h0;
            i_ack           <= 1'b0;
            d_ack           <= 1'b0;
            i_data          <= 32'h0;
            d_rdata         <= 32'h0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            err_r           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_data      <= grant_data;
                        last_grant_data <= grant_data;
                        rw              <= grant_data && d_rw;
                        last            <= req_last;
                        k               <= 2'd0;
                        addr            <= grant_data ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
                        wdata           <= grant_data ? d_wdata : 32'h0;
                        if (reserved || misaligned) begin
                            state <= DONE;
                            if (grant_data) begin
                                d_ack   <= 1'b1;
                                d_rdata <= 32'h0;
                            end else begin
                                i_ack  <= 1'b1;
                                i_data <= 32'h0;
                            end
`ifdef MEM_CTRL_ALIGN_CHECK_EN
                            err_r <= misaligned;
`endif
                        end else begin
                            state <= XFER;
                            // Clear the result so bits above 8N read as zero.
                            if (!grant_data) begin
                                i_data <= 32'h0;
                            end else if (!d_rw) begin
                                d_rdata <= 32'h0;
                            end
                        end
                    end
                end
                XFER: begin
                    if (!rw) begin
                        if (owner_data) begin
                            d_rdata[{lane, 3'b000} +: 8] <= mem_rdata;
                        end else begin
                            i_data[{lane, 3'b000} +: 8] <= mem_rdata;
                        end
                    end
                    k <= k + 2'd1;
                    if (k == last) begin
                        state <= DONE;
                        if (owner_data) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
                    err_r <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequencer and arbiter that shares one byte-wide, 256-location memory between the instruction-fetch port and the data (MEM-stage) port of the pipelined core. It accepts one access at a time from either requester, grants ties round-robin, and runs multi-byte accesses (byte, half-word, word) as big-endian byte-serial cycles on the memory port. It returns read data or write completion through a single-cycle acknowledge.

## Interface
- ADDR_W, 8, memory address width; the upper address bits of requests are ignored.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  32  fetch byte address; always a word read.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_data  out  32  fetched word, valid while i_ack=1.
- d_req  in  1  data request; held with d_rw, d_size, d_addr and d_wdata until d_ack.
- d_rw  in  1  0 = read, 1 = write.
- d_size  in  2  00 byte, 01 half-word, 10 word, 11 reserved.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data, right-aligned (byte = [7:0], half = [15:0]).
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  32  read data, zero-extended, valid while d_ack=1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write the byte this cycle.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  combinational read byte for the current mem_addr.
- err  out  1  misalignment flag (see Configuration).

## Operation
- FSM states: IDLE, XFER, DONE. The reset state is IDLE.
- IDLE:
  - If any request is high, latch the winner's command, clear the byte counter k, and go to XFER.
  - The byte count N is 1, 2 or 4 by d_size. A fetch always has N = 4.
- Arbitration:
  - A single request wins alone.
  - On a tie, the port not granted last wins. A last_grant register tracks this; reset sets it to "fetch", so data wins the first tie.
- XFER, one byte per cycle:
  - mem_en=1, mem_addr=(addr+k) mod 2^ADDR_W.
  - Byte k maps to bits [8(N-k)-1 : 8(N-k)-8], big-endian.
  - Write: mem_we=1 and mem_wdata = that byte of d_wdata.
  - Read: capture mem_rdata into that byte of the result register. Bits above 8N are 0.
  - After byte N-1, go to DONE.
- DONE:
  - Assert the winner's ack for exactly one cycle, with i_data or d_rdata valid, then return to IDLE.
  - The result register holds its value until the next read by the same port.
- d_size=11: no memory cycles. Go from IDLE to DONE directly, d_ack=1, d_rdata=0, nothing is written.
- Address wrap: an access at 0xFF with N=4 touches 0xFF, 0x00, 0x01, 0x02.
- Requesters must keep their inputs stable until ack. A request still high in IDLE after its ack is treated as a new access.
- Reset mid-operation:
  - The access is aborted with no ack.
  - Bytes already written remain; partial writes are permitted.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_data=0, d_rdata=0, err=0.

## Timing
- A request high in IDLE at edge T puts XFER in cycles T+1 through T+N, and the ack in cycle T+N+1. An access occupies N+2 cycles.
- Back-to-back word accesses: one completes every 6 cycles.
- All outputs are registered, except that mem_* are decoded from the state and counter registers (glitch-free, stable over the full cycle).
- mem_rdata is sampled at the end of each read XFER cycle.
- The losing requester waits without loss. Its worst-case wait is one full access of the other port.

## Configuration
- MEM_CTRL_ALIGN_CHECK_EN defined:
  - Misaligned requests are rejected with no mem_en cycles: a half-word with addr[0]=1, a word with addr[1:0]≠0, or a fetch with addr[1:0]≠0.
  - The FSM goes IDLE→DONE, and the ack pulses with err=1 in the same cycle and read data=0.
  - err is otherwise 0.
- Undefined:
  - err is tied to 0.
  - Misaligned accesses run byte-serially as above, including wrap.

## Test plan
- Data word write of 0xDEADBEEF to 0x10, then word read of 0x10: mem bytes 0x10..0x13 = DE,AD,BE,EF; d_rdata=0xDEADBEEF; d_ack in cycle T+5 for each.
- Half-word write of 0x1234 to 0x20, then byte read of 0x21: mem[0x20]=0x12, mem[0x21]=0x34; d_rdata=0x00000034 after 3 cycles.
- i_req and d_req raised in the same cycle after reset: data served first, fetch acked 6 cycles later. Next tie: fetch wins.
- Word read at 0xFE with the macro undefined: mem_addr sequence FE,FF,00,01. With the macro defined: no mem_en, d_ack=1 and err=1 at T+1.
- reset asserted during byte 2 of a word write: all outputs 0 at once, no d_ack, FSM in IDLE, bytes 0–1 written and bytes 2–3 unchanged.
- d_size=11 write: d_ack at T+1, mem_en never asserted, d_rdata=0.
